mem_req_arbiter: RTL and testbench

- Round-robin arbiter between five memory requesters and the single read/write port of qspi_innermem: CPU instruction read, CPU data read, CPU data write, UART read, UART write.
- Accepts one transaction at a time and issues it as a one-cycle request pulse to memory.
- Waits for read_valid/write_finish, then returns a registered done pulse and read data to the requester that owns the grant.
- Sits between cpu_top/uart_top and qspi_innermem as a replacement for the current pass-through gathering logic.

---
 rtl/mem_req_arbiter_if.sv | 27 ++
 rtl/mem_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Memory-side port of the arbiter: single read/write channel toward qspi_innermem.
interface mem_req_arbiter_if;
  logic        read_req;
  logic        write_req;
  logic        read_w;
  logic        read_hw;
  logic        write_w;
  logic        write_hw;
  logic [31:0] read_adr;
  logic [31:0] write_adr;
  logic [31:0] write_data;
  logic        read_valid;
  logic [31:0] read_data;
  logic        write_finish;

  modport master (
    output read_req, write_req, read_w, read_hw, write_w, write_hw,
    output read_adr, write_adr, write_data,
    input  read_valid, read_data, write_finish
  );

  modport slave (
    input  read_req, write_req, read_w, read_hw, write_w, write_hw,
    input  read_adr, write_adr, write_data,
    output read_valid, read_data, write_finish
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter of five CPU/UART requesters onto one memory port, one transaction at a time.
// Optional response timeout enabled by defining ARB_TIMEOUT_EN.
module mem_req_arbiter #(
  parameter int NSRC        = 5,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read_req,
  input  logic        i_read_w,
  input  logic        i_read_hw,
  input  logic [31:0] i_read_adr,
  input  logic        d_read_req,
  input  logic        d_read_w,
  input  logic        d_read_hw,
  input  logic [31:0] d_read_adr,
  input  logic        d_write_req,
  input  logic        d_write_w,
  input  logic        d_write_hw,
  input  logic [31:0] d_write_adr,
  input  logic [31:0] d_write_data,
  input  logic        u_read_req,
  input  logic        u_read_w,
  input  logic [31:0] u_read_adr,
  input  logic        u_write_req,
  input  logic        u_write_w,
  input  logic [31:0] u_write_adr,
  input  logic [31:0] u_write_data,
  mem_req_arbiter_if.master mem,
  output logic        i_read_done,
  output logic        d_read_done,
  output logic        d_write_done,
  output logic        u_read_done,
  output logic        u_write_done,
  output logic [31:0] rdata,
  output logic        arb_err
);
  localparam int SW = $clog2(NSRC);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT_RD = 3'd2;
  localparam logic [2:0] WAIT_WR = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [NSRC-1:0]       req, src_wr, src_w, src_hw, done;
  logic [NSRC-1:0][31:0] src_adr, src_data;

  assign req      = {u_write_req, u_read_req, d_write_req, d_read_req, i_read_req};
  assign src_wr   = 5'b10100;
  assign src_w    = {u_write_w, u_read_w, d_write_w, d_read_w, i_read_w};
  assign src_hw   = {1'b0, 1'b0, d_write_hw, d_read_hw, i_read_hw};
  assign src_adr  = {u_write_adr, u_read_adr, d_write_adr, d_read_adr, i_read_adr};
  assign src_data = {u_write_data, 32'h0, d_write_data, 32'h0, 32'h0};

  logic [2:0]    state;
  logic [SW-1:0] ptr, gnt, pick;
  logic [SW:0]   scan;
  logic          pick_vld;
  logic          l_wr, l_w, l_hw;
  logic [31:0]   l_adr, l_data;
  logic          wait_st, resp, tmo, expire;

  // ptr is the scan start (one past the last grant), so source 0 leads after reset
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan     = '0;
    for (int k = NSRC-1; k >= 0; k--) begin
      scan = {1'b0, ptr} + (SW+1)'(k);
      if (scan >= (SW+1)'(NSRC)) scan = scan - (SW+1)'(NSRC);
      if (req[scan[SW-1:0]]) begin
        pick     = scan[SW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  assign wait_st = (state == WAIT_RD) || (state == WAIT_WR);
  assign resp    = ((state == WAIT_RD) && mem.read_valid) ||
                   ((state == WAIT_WR) && mem.write_finish);
  assign expire  = wait_st && !resp && tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      l_wr   <= 1'b0;
      l_w    <= 1'b0;
      l_hw   <= 1'b0;
      l_adr  <= '0;
      l_data <= '0;
      rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          gnt    <= pick;
          l_wr   <= src_wr[pick];
          l_w    <= src_w[pick];
          l_hw   <= src_hw[pick];
          l_adr  <= src_adr[pick];
          l_data <= src_data[pick];
          state  <= ISSUE;
        end
        ISSUE:   state <= l_wr ? WAIT_WR : WAIT_RD;
        WAIT_RD: if (mem.read_valid) begin
          rdata <= mem.read_data;
          state <= DONE;
        end else if (tmo) begin
          rdata <= 32'hdeadbeef;
          state <= DONE;
        end
        WAIT_WR: if (mem.write_finish || tmo) state <= DONE;
        DONE: begin
          ptr   <= (gnt == SW'(NSRC-1)) ? '0 : gnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC+1);
  logic [CW-1:0] cnt;

  assign tmo = (cnt == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      arb_err <= 1'b0;
    end else begin
      if (state == ISSUE)       cnt <= '0;
      else if (wait_st && !tmo) cnt <= cnt + 1'b1;
      if (expire) arb_err <= 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign arb_err = 1'b0;
`endif

  assign mem.read_req   = (state == ISSUE) && !l_wr;
  assign mem.write_req  = (state == ISSUE) &&  l_wr;
  assign mem.read_w     = !l_wr && l_w;
  assign mem.read_hw    = !l_wr && l_hw;
  assign mem.write_w    =  l_wr && l_w;
  assign mem.write_hw   =  l_wr && l_hw;
  assign mem.read_adr   = l_wr ? 32'h0 : l_adr;
  assign mem.write_adr  = l_wr ? l_adr : 32'h0;
  assign mem.write_data = l_wr ? l_data : 32'h0;

  assign done = (state == DONE) ? (NSRC'(1) << gnt) : '0;
  assign {u_write_done, u_read_done, d_write_done, d_read_done, i_read_done} = done;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter against a transaction-level round-robin model.
module tb_mem_req_arbiter;
  localparam int TO =
`ifdef ARB_TIMEOUT_EN
    16;
`else
    1023;
`endif

  logic        clk, rst_n;
  logic [4:0]  req, w, hw;
  logic [31:0] adr [5];
  logic [31:0] wdat [5];
  logic        i_read_done, d_read_done, d_write_done, u_read_done, u_write_done;
  logic [31:0] rdata;
  logic        arb_err;
  logic [4:0]  done_v;

  mem_req_arbiter_if mem();

  mem_req_arbiter #(.NSRC(5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read_req(req[0]), .i_read_w(w[0]), .i_read_hw(hw[0]), .i_read_adr(adr[0]),
    .d_read_req(req[1]), .d_read_w(w[1]), .d_read_hw(hw[1]), .d_read_adr(adr[1]),
    .d_write_req(req[2]), .d_write_w(w[2]), .d_write_hw(hw[2]), .d_write_adr(adr[2]),
    .d_write_data(wdat[2]),
    .u_read_req(req[3]), .u_read_w(w[3]), .u_read_adr(adr[3]),
    .u_write_req(req[4]), .u_write_w(w[4]), .u_write_adr(adr[4]), .u_write_data(wdat[4]),
    .mem(mem),
    .i_read_done(i_read_done), .d_read_done(d_read_done), .d_write_done(d_write_done),
    .u_read_done(u_read_done), .u_write_done(u_write_done),
    .rdata(rdata), .arb_err(arb_err)
  );

  assign done_v = {u_write_done, u_read_done, d_write_done, d_read_done, i_read_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_wr(input int s);
    return (s == 2) || (s == 4);
  endfunction

  task automatic raise(input int s);
    req[s]  = 1'b1;
    adr[s]  = $urandom;
    w[s]    = 1'($urandom_range(0, 1));
    hw[s]   = (s < 3) && !w[s] && ($urandom_range(0, 1) == 1);
    wdat[s] = is_wr(s) ? $urandom : 32'h0;
  endtask

  // model state: next scan start, pending grant, expected done source
  int          nxt, pend, done_src, wcnt, win;
  logic [31:0] cap, m_rdata, e_adr, e_data;
  logic [1:0]  e_size;
  logic [4:0]  exp_done;
  bit          e_wr, iss, did_rst;

  task automatic check_fields(input string tag);
    if (e_wr) begin
      chk({tag, "_wadr"},  mem.write_adr, e_adr);
      chk({tag, "_wdata"}, mem.write_data, e_data);
      chk({tag, "_wsize"}, {30'h0, mem.write_w, mem.write_hw}, {30'h0, e_size});
    end else begin
      chk({tag, "_radr"},  mem.read_adr, e_adr);
      chk({tag, "_rsize"}, {30'h0, mem.read_w, mem.read_hw}, {30'h0, e_size});
    end
  endtask

  task automatic model_reset();
    nxt = 0; pend = -1; done_src = -1; wcnt = 0; m_rdata = '0; cap = '0;
    req = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    w = '0; hw = '0;
    for (int i = 0; i < 5; i++) begin adr[i] = '0; wdat[i] = '0; end
    mem.read_valid = 1'b0; mem.write_finish = 1'b0; mem.read_data = '0;
    model_reset();
    did_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {25'h0, mem.read_req, mem.write_req, done_v}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_err", {31'h0, arb_err}, 32'h0);
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) raise(s);

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      // reset while a read/write is outstanding in a WAIT state
      if (!did_rst && cyc > 700 && pend >= 0) begin
        did_rst = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {20'h0, mem.read_req, mem.write_req, mem.read_w, mem.read_hw,
                          mem.write_w, mem.write_hw, arb_err, done_v}, 32'h0);
        chk("arst_radr", mem.read_adr, 32'h0);
        chk("arst_wadr", mem.write_adr, 32'h0);
        chk("arst_wdata", mem.write_data, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        model_reset();
        mem.read_valid = 1'b0; mem.write_finish = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem.read_valid = 1'b1;
        mem.read_data  = $urandom;
        for (int s = 0; s < 5; s++) raise(s);
        continue;
      end

      iss = 1'b0;
      if (done_src >= 0 && !is_wr(done_src)) m_rdata = cap;
      exp_done = '0;
      if (done_src >= 0) exp_done[done_src] = 1'b1;
      chk("done", {27'h0, done_v}, {27'h0, exp_done});
      chk("rdata", rdata, m_rdata);
      chk("arb_err", {31'h0, arb_err}, 32'h0);
      chk("overlap", {31'h0, mem.read_req & mem.write_req}, 32'h0);

      if (mem.read_req || mem.write_req) begin
        if (pend >= 0) chk("single_issue", 32'h1, 32'h0);
        else begin
          win = -1;
          for (int k = 0; k < 5; k++)
            if (win < 0 && req[(nxt + k) % 5]) win = (nxt + k) % 5;
          if (win < 0) chk("issue_no_req", 32'h1, 32'h0);
          else begin
            e_wr = is_wr(win); e_adr = adr[win]; e_data = wdat[win];
            e_size = {w[win], hw[win]};
            chk("grant_rd", {31'h0, mem.read_req}, {31'h0, !e_wr});
            chk("grant_wr", {31'h0, mem.write_req}, {31'h0, e_wr});
            check_fields("issue");
            pend = win; nxt = (win + 1) % 5; wcnt = $urandom_range(1, 4); iss = 1'b1;
          end
        end
      end else if (pend >= 0) check_fields("hold");

      if (done_src >= 0) begin req[done_src] = 1'b0; done_src = -1; end

      mem.read_valid = 1'b0; mem.write_finish = 1'b0; mem.read_data = $urandom;
      if (pend >= 0 && !iss) begin
        wcnt--;
        if (wcnt == 0) begin
          done_src = pend; pend = -1;
          if (is_wr(done_src)) mem.write_finish = 1'b1;
          else begin
            cap = $urandom; mem.read_data = cap; mem.read_valid = 1'b1;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          if (e_wr) mem.read_valid = 1'b1;
          else      mem.write_finish = 1'b1;
        end
      end else if (pend < 0 && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) mem.read_valid = 1'b1;
        else                           mem.write_finish = 1'b1;
      end

      for (int s = 0; s < 5; s++)
        if (!req[s] && $urandom_range(0, 3) == 0) raise(s);
    end

`ifdef ARB_TIMEOUT_EN
    begin
      int t_iss, t_done;
      @(negedge clk);
      rst_n = 1'b0; model_reset();
      mem.read_valid = 1'b0; mem.write_finish = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      raise(3);
      t_iss = -1; t_done = -1;
      for (int c = 0; c < 60 && t_done < 0; c++) begin
        @(negedge clk);
        if (mem.read_req && t_iss < 0) t_iss = c;
        if (u_read_done) begin t_done = c; req[3] = 1'b0; end
      end
      chk("tmo_latency", 32'(t_done - t_iss), 32'd18);
      chk("tmo_rdata", rdata, 32'hdeadbeef);
      chk("tmo_err", {31'h0, arb_err}, 32'h1);
      repeat (5) @(negedge clk);
      chk("tmo_err_sticky", {31'h0, arb_err}, 32'h1);
      rst_n = 1'b0;
      #1 chk("tmo_err_rst", {31'h0, arb_err}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
